fp_to_int_pipe: RTL and testbench
=================================

Name: fp_to_int_pipe

Overview:
- Pipelined float-to-integer converter, the reverse of the integer-to-float path. Implements fcvt.w.s / fcvt.wu.s semantics.
- Accepts one IEEE-754 operand per cycle under valid/ready and returns a saturated signed or unsigned integer plus fflags.
- Two register stages: stage 1 decodes and aligns, stage 2 rounds and saturates. Sits in the FPU beside the int-to-fp path and shares its rm encoding and fflags layout.

Parameters:
- EXPWIDTH, 8: exponent field width.
- PRECISION, 24: significand width including the hidden bit.
- INTWIDTH, 32: result integer width.
- TAGWIDTH, 8: width of the opaque tag (warp/reg id) passed through alongside the operation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  block can accept an operand this cycle.
- a_i  in  EXPWIDTH+PRECISION  float operand {sign, exp, frac}.
- is_signed_i  in  1  1 = signed target, 0 = unsigned target.
- rm_i  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 behave as RNE.
- tag_i  in  TAGWIDTH  passthrough tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  INTWIDTH  converted integer.
- fflags_o  out  5  {NV, DZ, OF, UF, NX}. DZ, OF and UF are always 0.
- tag_o  out  TAGWIDTH  tag carried with the result.

Behaviour:
- Reset (async, rst_n=0): stage valids clear, out_valid_o=0, result_o=0, fflags_o=0, tag_o=0. All in-flight operations are discarded. in_ready_o is 1 once reset is released.
- Handshake and flow control:
  - Transfer happens on valid&&ready at each port.
  - s2_ready = !s2_valid || out_ready_i.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready_o = s1_ready.
  - Latency is 2 cycles from input accept to out_valid_o with no backpressure. Throughput is 1 per cycle.
  - While out_valid_o=1 and out_ready_i=0, result_o, fflags_o and tag_o hold stable, and no stage advances into an occupied stage.
  - Ordering is strictly in order; there is no bubble insertion.
- Stage 1 (decode and align):
  - Classify the operand: NaN (exp all-ones, frac≠0), Inf, zero/subnormal, or normal.
  - Unbiased exponent e = exp − (2^(EXPWIDTH−1)−1). Subnormals are treated as magnitude <1 (e < −1 class, sticky = 1 when frac≠0).
  - Build the magnitude as the hidden bit plus fraction, shifted to an INTWIDTH+1-bit integer part plus a guard bit and a sticky bit.
  - If e ≥ INTWIDTH+1, set the overflow-class flag and skip the shift.
  - Register the sign, class, integer part, guard, sticky, rm, is_signed and tag.
- Stage 2 (round):
  - inexact = guard | sticky.
  - Round-up rule by mode:
    - RNE: guard && (sticky || lsb).
    - RTZ: never.
    - RDN: sign && inexact.
    - RUP: !sign && inexact.
    - RMM: guard.
  - Increment the integer part by the round-up bit, in INTWIDTH+1 bits plus a carry.
- Stage 2 (saturate):
  - Signed target: the valid range is −2^(INTWIDTH−1) .. 2^(INTWIDTH−1)−1, with the test applied after rounding and sign applied.
  - Unsigned target: the valid range is 0 .. 2^INTWIDTH−1. A negative rounded magnitude of 0 (e.g. −0.3 RTZ) is valid and gives 0 with NX.
  - NaN gives the maximum positive value (signed 0x7FFFFFFF, unsigned 0xFFFFFFFF) with NV.
  - +Inf or positive out-of-range gives that same maximum with NV.
  - −Inf or negative out-of-range gives the minimum (signed 0x80000000, unsigned 0) with NV.
  - NV set forces NX=0. Otherwise NX = inexact.
  - ±0 gives 0 with no flags.
  - The result is the two's complement of the magnitude when sign=1.
- Simultaneous accept at the input and drain at the output in the same cycle is permitted in every stage.

Test Plan:
- 1.5 (0x3FC00000), signed, RNE → 0x00000002, fflags 0x01. Same operand with RTZ → 0x00000001, fflags 0x01.
- −1.5 (0xBFC00000), signed: RDN → 0xFFFFFFFE, fflags 0x01; RUP → 0xFFFFFFFF, fflags 0x01. 2.5 (0x40200000) RNE → 0x00000002; 2.5 RMM → 0x00000003.
- NaN 0x7FC00000 signed → 0x7FFFFFFF, fflags 0x10. 2^31 (0x4F000000) signed → 0x7FFFFFFF, fflags 0x10; unsigned → 0x80000000, fflags 0x00. −2^31 (0xCF000000) signed → 0x80000000, fflags 0x00.
- Unsigned target: −0.3 (0xBE99999A) RTZ → 0, fflags 0x01; −0.7 (0xBF333333) RNE → 0, fflags 0x10; −Inf → 0, fflags 0x10.
- Back-to-back stream of 8 operands with out_ready_i low for cycles 3-6:
  - in_ready_o deasserts after two operands are held.
  - Output stays stable while stalled.
  - All 8 results emerge in order with the correct tags, and none is lost or duplicated.
- Assert rst_n=0 with two operations in flight → out_valid_o drops immediately and no stale result appears after release. The next accepted operand returns after exactly 2 cycles.

Source files
------------

// File: rtl/fp_to_int_pipe.sv
// Two-stage float-to-integer converter (fcvt.w.s / fcvt.wu.s).
// Stage 1 decodes and aligns; stage 2 rounds, saturates and flags.
module fp_to_int_pipe #(
   parameter int EXPWIDTH  = 8,
   parameter int PRECISION = 24,
   parameter int INTWIDTH  = 32,
   parameter int TAGWIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [EXPWIDTH+PRECISION-1:0] a_i,
   input  logic                          is_signed_i,
   input  logic [2:0]                    rm_i,
   input  logic [TAGWIDTH-1:0]           tag_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [INTWIDTH-1:0]           result_o,
   output logic [4:0]                    fflags_o,
   output logic [TAGWIDTH-1:0]           tag_o
);

   localparam int W    = EXPWIDTH + PRECISION;
   localparam int IW1  = INTWIDTH + 1;
   localparam int FW   = IW1 + PRECISION;
   localparam int BIAS = 2**(EXPWIDTH-1) - 1;
   localparam int SHW  = $clog2(IW1 + 1);

   localparam logic [IW1:0] LIM_SP = {3'b000, {(INTWIDTH-1){1'b1}}};
   localparam logic [IW1:0] LIM_SN = {3'b001, {(INTWIDTH-1){1'b0}}};
   localparam logic [IW1:0] LIM_UP = {2'b00, {INTWIDTH{1'b1}}};

   logic                 w_s1_ready;
   logic                 w_s2_ready;

   logic                 w_sign;
   logic [EXPWIDTH-1:0]  w_exp;
   logic [PRECISION-2:0] w_frac;
   logic                 w_nan;
   int                   w_e;
   logic                 w_ovf;
   logic [IW1-1:0]       w_int;
   logic                 w_g;
   logic                 w_s;
   logic [SHW-1:0]       w_sh;
   logic [FW-1:0]        w_fix;

   logic                 r1_valid;
   logic                 r1_sign;
   logic                 r1_nan;
   logic                 r1_ovf;
   logic [IW1-1:0]       r1_int;
   logic                 r1_g;
   logic                 r1_s;
   logic [2:0]           r1_rm;
   logic                 r1_signed;
   logic [TAGWIDTH-1:0]  r1_tag;

   logic                 w_inx;
   logic                 w_rup;
   logic [IW1:0]         w_sum;
   logic                 w_ok;
   logic [INTWIDTH-1:0]  w_maxp;
   logic [INTWIDTH-1:0]  w_minn;
   logic [INTWIDTH-1:0]  w_res;
   logic [4:0]           w_flags;

   logic                 r2_valid;
   logic [INTWIDTH-1:0]  r2_res;
   logic [4:0]           r2_flags;
   logic [TAGWIDTH-1:0]  r2_tag;

   assign w_s2_ready = !r2_valid || out_ready_i;
   assign w_s1_ready = !r1_valid || w_s2_ready;
   assign in_ready_o = w_s1_ready;

   assign w_sign = a_i[W-1];
   assign w_exp  = a_i[W-2 -: EXPWIDTH];
   assign w_frac = a_i[PRECISION-2:0];
   assign w_nan  = (&w_exp) && (|w_frac);
   assign w_e    = int'(w_exp) - BIAS;

   // Hidden bit sits just below the binary point at shift 0 (e = -1).
   always_comb begin
      w_ovf = 1'b0;
      w_int = '0;
      w_g   = 1'b0;
      w_s   = 1'b0;
      w_sh  = '0;
      w_fix = '0;
      if (w_nan) begin
         w_ovf = 1'b0;
      end else if (w_exp == '0) begin
         w_s = |w_frac;
      end else if (w_e >= IW1) begin
         w_ovf = 1'b1;
      end else if (w_e < -1) begin
         w_s = 1'b1;
      end else begin
         w_sh  = SHW'(w_e + 1);
         w_fix = FW'({1'b1, w_frac}) << w_sh;
         w_int = w_fix[FW-1 -: IW1];
         w_g   = w_fix[PRECISION-1];
         w_s   = |w_fix[PRECISION-2:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid  <= 1'b0;
         r1_sign   <= 1'b0;
         r1_nan    <= 1'b0;
         r1_ovf    <= 1'b0;
         r1_int    <= '0;
         r1_g      <= 1'b0;
         r1_s      <= 1'b0;
         r1_rm     <= '0;
         r1_signed <= 1'b0;
         r1_tag    <= '0;
      end else if (w_s1_ready) begin
         r1_valid <= in_valid_i;
         if (in_valid_i) begin
            r1_sign   <= w_sign;
            r1_nan    <= w_nan;
            r1_ovf    <= w_ovf;
            r1_int    <= w_int;
            r1_g      <= w_g;
            r1_s      <= w_s;
            r1_rm     <= rm_i;
            r1_signed <= is_signed_i;
            r1_tag    <= tag_i;
         end
      end
   end

   assign w_inx = r1_g | r1_s;

   always_comb begin
      case (r1_rm)
         3'd1:    w_rup = 1'b0;
         3'd2:    w_rup = r1_sign & w_inx;
         3'd3:    w_rup = !r1_sign & w_inx;
         3'd4:    w_rup = r1_g;
         default: w_rup = r1_g & (r1_s | r1_int[0]);
      endcase
   end

   assign w_sum = {1'b0, r1_int} + {{IW1{1'b0}}, w_rup};

   always_comb begin
      if (r1_signed) begin
         w_ok   = r1_sign ? (w_sum <= LIM_SN) : (w_sum <= LIM_SP);
         w_maxp = {1'b0, {(INTWIDTH-1){1'b1}}};
         w_minn = {1'b1, {(INTWIDTH-1){1'b0}}};
      end else begin
         w_ok   = r1_sign ? (w_sum == '0) : (w_sum <= LIM_UP);
         w_maxp = {INTWIDTH{1'b1}};
         w_minn = '0;
      end
   end

   // NaN saturates positive regardless of its sign bit.
   always_comb begin
      w_res   = '0;
      w_flags = '0;
      if (r1_nan) begin
         w_res   = w_maxp;
         w_flags = 5'b10000;
      end else if (r1_ovf || !w_ok) begin
         w_res   = r1_sign ? w_minn : w_maxp;
         w_flags = 5'b10000;
      end else begin
         w_res   = r1_sign ? -w_sum[INTWIDTH-1:0] : w_sum[INTWIDTH-1:0];
         w_flags = {4'b0000, w_inx};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r2_res   <= '0;
         r2_flags <= '0;
         r2_tag   <= '0;
      end else if (w_s2_ready) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_res   <= w_res;
            r2_flags <= w_flags;
            r2_tag   <= r1_tag;
         end
      end
   end

   assign out_valid_o = r2_valid;
   assign result_o    = r2_res;
   assign fflags_o    = r2_flags;
   assign tag_o       = r2_tag;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Scoreboard bench for fp_to_int_pipe: directed vectors, stall stream,
// and reset with operations in flight.
module tb_fp_to_int_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] a_i = '0;
   logic        is_signed_i = 1'b0;
   logic [2:0]  rm_i = '0;
   logic [7:0]  tag_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;
   logic [7:0]  tag_o;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  fl;
      logic [7:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   logic held_v = 1'b0;
   exp_t held;
   logic saw_block = 1'b0;

   fp_to_int_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .a_i(a_i), .is_signed_i(is_signed_i), .rm_i(rm_i),
      .tag_i(tag_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .result_o(result_o),
      .fflags_o(fflags_o), .tag_o(tag_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (in_valid_i && !in_ready_o) saw_block = 1'b1;
      if (out_valid_o && !out_ready_i) begin
         if (held_v) chk("stall_hold", {result_o, fflags_o, tag_o}, held);
         held   = {result_o, fflags_o, tag_o};
         held_v = 1'b1;
      end else begin
         held_v = 1'b0;
      end
      if (out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got tag %0h want none", tag_o);
         end else begin
            e = sb.pop_front();
            chk($sformatf("result_t%0h", e.tag), result_o, e.res);
            chk($sformatf("fflags_t%0h", e.tag), fflags_o, e.fl);
            chk($sformatf("tag_t%0h", e.tag), tag_o, e.tag);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic sg,
                       input logic [2:0] rm, input logic [7:0] tg,
                       input logic [31:0] er, input logic [4:0] ef);
      int k;
      a_i = a;
      is_signed_i = sg;
      rm_i = rm;
      tag_i = tg;
      in_valid_i = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready_o && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (!in_ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got ready 0 want 1 tag %0h", tg);
      end else begin
         sb.push_back(exp_t'{er, ef, tg});
      end
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         k++;
         @(posedge clk);
      end
      repeat (2) @(posedge clk);
      chk(nm, sb.size(), 0);
   endtask

   logic [31:0] stream_a [8] = '{32'h3F800000, 32'h40000000,
      32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
      32'h40E00000, 32'h41000000};

   initial begin
      #12;
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_fflags", fflags_o, 0);
      chk("rst_tag", tag_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready_o, 1);

      send(32'h3FC00000, 1, 0, 8'h01, 32'h00000002, 5'h01);
      send(32'h3FC00000, 1, 1, 8'h02, 32'h00000001, 5'h01);
      send(32'hBFC00000, 1, 2, 8'h03, 32'hFFFFFFFE, 5'h01);
      send(32'hBFC00000, 1, 3, 8'h04, 32'hFFFFFFFF, 5'h01);
      send(32'h40200000, 1, 0, 8'h05, 32'h00000002, 5'h01);
      send(32'h40200000, 1, 4, 8'h06, 32'h00000003, 5'h01);
      send(32'h7FC00000, 1, 0, 8'h07, 32'h7FFFFFFF, 5'h10);
      send(32'h4F000000, 1, 0, 8'h08, 32'h7FFFFFFF, 5'h10);
      send(32'h4F000000, 0, 0, 8'h09, 32'h80000000, 5'h00);
      send(32'hCF000000, 1, 0, 8'h0A, 32'h80000000, 5'h00);
      send(32'hBE99999A, 0, 1, 8'h0B, 32'h00000000, 5'h01);
      send(32'hBF333333, 0, 0, 8'h0C, 32'h00000000, 5'h10);
      send(32'hFF800000, 0, 0, 8'h0D, 32'h00000000, 5'h10);
      send(32'h7F800000, 1, 0, 8'h0E, 32'h7FFFFFFF, 5'h10);
      send(32'h80000000, 1, 0, 8'h0F, 32'h00000000, 5'h00);
      send(32'h00000001, 1, 3, 8'h10, 32'h00000001, 5'h01);
      send(32'h4F800000, 0, 0, 8'h11, 32'hFFFFFFFF, 5'h10);
      send(32'h40200000, 1, 7, 8'h12, 32'h00000002, 5'h01);
      send(32'h7FC00000, 0, 1, 8'h13, 32'hFFFFFFFF, 5'h10);
      drain("drain_directed");

      saw_block = 1'b0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(stream_a[i], 1, 1, 8'h20 + 8'(i), 32'(i + 1), 5'h00);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready_i = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            out_ready_i = 1'b1;
         end
      join
      drain("drain_stream");
      chk("in_ready_block", saw_block, 1);

      send(32'h40800000, 1, 1, 8'h30, 32'h00000004, 5'h00);
      send(32'h40A00000, 1, 1, 8'h31, 32'h00000005, 5'h00);
      rst_n = 1'b0;
      #1;
      chk("rst_flight_valid", out_valid_o, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      a_i = 32'h40400000;
      is_signed_i = 1'b1;
      rm_i = 3'd1;
      tag_i = 8'h40;
      in_valid_i = 1'b1;
      @(negedge clk);
      chk("lat_accept", in_ready_o, 1);
      sb.push_back(exp_t'{32'h3, 5'h00, 8'h40});
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      chk("lat_cycle1", out_valid_o, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle2", out_valid_o, 1);
      drain("drain_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
